// File: rtl/filter_mode_ctrl_if.sv
// Control/status bundle between the VGA front end and filter_mode_ctrl.
// FILTER_CTRL_DIRECT_SEL_EN adds the sel_valid/sel_mode direct-select pair.
interface filter_mode_ctrl_if;
   logic       v_sync;
   logic       btn_next;
   logic       btn_prev;
   logic       auto_en;
   logic [2:0] state;
   logic       pending;
   logic       mode_update;
`ifdef FILTER_CTRL_DIRECT_SEL_EN
   logic       sel_valid;
   logic [2:0] sel_mode;

   modport master (output v_sync, btn_next, btn_prev, auto_en, sel_valid, sel_mode,
                   input  state, pending, mode_update);
   modport slave  (input  v_sync, btn_next, btn_prev, auto_en, sel_valid, sel_mode,
                   output state, pending, mode_update);
`else
   modport master (output v_sync, btn_next, btn_prev, auto_en,
                   input  state, pending, mode_update);
   modport slave  (input  v_sync, btn_next, btn_prev, auto_en,
                   output state, pending, mode_update);
`endif
endinterface

// File: rtl/filter_mode_ctrl.sv
// Filter/zoom mode sequencer: debounced next/prev buttons, frame-aligned commit, auto slideshow.
// FILTER_CTRL_DIRECT_SEL_EN enables an absolute-target direct select.
//
// mode   | meaning
// NORMAL | pass-through
// RED    | red channel only
// GREEN  | green channel only
// BLUE   | blue channel only
// GSCALE | greyscale
// ZOOM2  | 2x zoom
// ZOOM3  | 3x zoom
// ZOOM4  | 4x zoom
module filter_mode_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [7:0]  FRAMES_PER_MODE = 8'd60
) (
   input logic              clk,
   input logic              reset,
   filter_mode_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      NORMAL, RED, GREEN, BLUE, GSCALE, ZOOM2, ZOOM3, ZOOM4
   } mode_t;

   mode_t       state_q;
   logic        pending_q;
   logic        mode_update_q;
   logic        dir_up_q;
   logic [7:0]  frame_cnt_q;
   logic        vs_d_q;
   logic [1:0]  s1_q, s2_q, deb_q, deb_d;
   logic [15:0] cnt_q [2];
   logic [15:0] cnt_d [2];
   logic [1:0]  press;
   logic        boundary;
   logic        step_req;
`ifdef FILTER_CTRL_DIRECT_SEL_EN
   logic        abs_q;
   mode_t       tgt_q;
`endif

   // Index 0 is btn_next, index 1 is btn_prev.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = 16'd0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) deb_d[i] = s2_q[i];
            else                                    cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   assign press    = deb_d & ~deb_q;
   assign step_req = press[0] ^ press[1];
   assign boundary = vs_d_q & ~bus.v_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= NORMAL;
         pending_q     <= 1'b0;
         mode_update_q <= 1'b0;
         dir_up_q      <= 1'b0;
         frame_cnt_q   <= 8'd0;
         vs_d_q        <= 1'b0;
         s1_q          <= 2'b00;
         s2_q          <= 2'b00;
         deb_q         <= 2'b00;
         cnt_q[0]      <= 16'd0;
         cnt_q[1]      <= 16'd0;
`ifdef FILTER_CTRL_DIRECT_SEL_EN
         abs_q         <= 1'b0;
         tgt_q         <= NORMAL;
`endif
      end else begin
         s1_q          <= {bus.btn_prev, bus.btn_next};
         s2_q          <= s1_q;
         deb_q         <= deb_d;
         cnt_q[0]      <= cnt_d[0];
         cnt_q[1]      <= cnt_d[1];
         vs_d_q        <= bus.v_sync;
         mode_update_q <= 1'b0;
         if (!bus.auto_en) frame_cnt_q <= 8'd0;

         if (boundary) begin
            if (pending_q) begin
`ifdef FILTER_CTRL_DIRECT_SEL_EN
               if (abs_q) state_q <= tgt_q;
               else       state_q <= mode_t'(state_q + (dir_up_q ? 3'd1 : 3'd7));
`else
               state_q <= mode_t'(state_q + (dir_up_q ? 3'd1 : 3'd7));
`endif
               pending_q     <= 1'b0;
               mode_update_q <= 1'b1;
               frame_cnt_q   <= 8'd0;
            end else if (bus.auto_en) begin
               if (frame_cnt_q == FRAMES_PER_MODE - 8'd1) begin
                  state_q       <= mode_t'(state_q + 3'd1);
                  mode_update_q <= 1'b1;
                  frame_cnt_q   <= 8'd0;
               end else begin
                  frame_cnt_q   <= frame_cnt_q + 8'd1;
               end
            end
         end

         // Placed after the commit so a request arriving on the commit edge survives to the next frame.
`ifdef FILTER_CTRL_DIRECT_SEL_EN
         if (bus.sel_valid) begin
            pending_q <= 1'b1;
            abs_q     <= 1'b1;
            tgt_q     <= mode_t'(bus.sel_mode);
         end else if (step_req) begin
            pending_q <= 1'b1;
            abs_q     <= 1'b0;
            dir_up_q  <= press[0];
         end
`else
         if (step_req) begin
            pending_q <= 1'b1;
            dir_up_q  <= press[0];
         end
`endif
      end
   end

   assign bus.state       = state_q;
   assign bus.pending     = pending_q;
   assign bus.mode_update = mode_update_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Bench for filter_mode_ctrl: directed scenarios plus random button/auto traffic vs. a window-based model.
module tb_filter_mode_ctrl;
   localparam int D = 4;
   localparam int F = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   filter_mode_ctrl_if bus();

   filter_mode_ctrl #(.DEBOUNCE_CYCLES(16'd4), .FRAMES_PER_MODE(8'd3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: a button is accepted once its raw level, seen 2 edges late,
   // has sat at the opposite value for the last D samples.
   int hist_n[$];
   int hist_p[$];
   bit deb_n, deb_p, vprev;
   int m_mode, m_pend, m_dir, m_fc, m_mu;

   // Frame generator state.
   bit auto_vs = 1'b1;
   bit rand_frames = 1'b0;
   int fpos = 0;
   int flen = 40;

   function automatic bit settled(input int q[$], input bit v);
      for (int i = 0; i < D; i++) if (q[i] != int'(v)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit pn, pp, bnd;
      if (reset) begin
         hist_n.delete(); hist_p.delete();
         for (int i = 0; i < D + 2; i++) begin hist_n.push_back(0); hist_p.push_back(0); end
         deb_n = 0; deb_p = 0; vprev = 0;
         m_mode = 0; m_pend = 0; m_dir = 1; m_fc = 0; m_mu = 0;
      end else begin
         hist_n.push_back(int'(bus.btn_next)); void'(hist_n.pop_front());
         hist_p.push_back(int'(bus.btn_prev)); void'(hist_p.pop_front());
         pn = 0; pp = 0;
         if (settled(hist_n, !deb_n)) begin deb_n = !deb_n; pn = deb_n; end
         if (settled(hist_p, !deb_p)) begin deb_p = !deb_p; pp = deb_p; end
         bnd   = vprev && !bus.v_sync;
         vprev = bus.v_sync;
         m_mu  = 0;
         if (!bus.auto_en) m_fc = 0;
         if (bnd) begin
            if (m_pend != 0) begin
               m_mode = (m_mode + m_dir + 8) % 8;
               m_pend = 0; m_mu = 1; m_fc = 0;
            end else if (bus.auto_en) begin
               if (m_fc == F - 1) begin m_mode = (m_mode + 1) % 8; m_mu = 1; m_fc = 0; end
               else m_fc++;
            end
         end
         if (pn != pp) begin m_pend = 1; m_dir = pn ? 1 : -1; end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("state", 32'(bus.state), 32'(m_mode));
      check("pending", 32'(bus.pending), 32'(m_pend));
      check("mode_update", 32'(bus.mode_update), 32'(m_mu));
      if (auto_vs) begin
         fpos++;
         if (fpos >= flen) begin
            fpos = 0;
            flen = rand_frames ? int'($urandom_range(16, 40)) : 40;
         end
         bus.v_sync = (fpos < flen - 3);
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input bit nxt, input int hold);
      if (nxt) bus.btn_next = 1'b1; else bus.btn_prev = 1'b1;
      steps(hold);
      bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
      steps(D + 4);
   endtask

   task automatic to_frame_start();
      for (int i = 0; i < 100 && fpos != 0; i++) step();
   endtask

   initial begin
      reset = 1'b1;
      bus.v_sync = 1'b1; bus.btn_next = 1'b1; bus.btn_prev = 1'b0; bus.auto_en = 1'b0;
`ifdef FILTER_CTRL_DIRECT_SEL_EN
      bus.sel_valid = 1'b0; bus.sel_mode = 3'd0;
`endif
      // Reset with button held and v_sync toggling.
      auto_vs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_state", 32'(bus.state), 32'd0);
         check("rst_pending", 32'(bus.pending), 32'd0);
         bus.v_sync = ~bus.v_sync;
      end
      bus.v_sync = 1'b1; fpos = 0; flen = 40; auto_vs = 1'b1;
      reset = 1'b0;
      steps(5);
      check("deb_not_yet", 32'(bus.pending), 32'd0);
      step();
      check("deb_accepted", 32'(bus.pending), 32'd1);
      bus.btn_next = 1'b0;
      to_frame_start();
      check("commit_0to1", 32'(bus.state), 32'd1);

      // Bounce: never stable for D samples.
      for (int i = 0; i < 10; i++) begin bus.btn_next = ~bus.btn_next; steps(2); end
      bus.btn_next = 1'b0;
      steps(6);
      check("bounce_pending", 32'(bus.pending), 32'd0);
      to_frame_start();
      check("bounce_state", 32'(bus.state), 32'd1);

      // Wrap: prev twice to reach 7, then two nexts in one frame.
      press(1'b0, D + 3); to_frame_start();
      press(1'b0, D + 3); to_frame_start();
      check("wrap_down", 32'(bus.state), 32'd7);
      press(1'b1, D + 2); press(1'b1, D + 2); to_frame_start();
      check("wrap_up", 32'(bus.state), 32'd0);

      // Auto cycle from 2, with a manual prev in the fourth frame.
      press(1'b1, D + 3); to_frame_start();
      press(1'b1, D + 3); to_frame_start();
      bus.auto_en = 1'b1;
      for (int f = 0; f < 7; f++) begin
         if (f == 3) press(1'b0, D + 3);
         steps(1); to_frame_start();
      end
      bus.auto_en = 1'b0;

      // Simultaneous presses cancel.
      steps(2);
      bus.btn_next = 1'b1; bus.btn_prev = 1'b1;
      steps(D + 4);
      bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
      steps(D + 4);
      to_frame_start();

      // Press whose acceptance lands on a commit edge.
      press(1'b0, D + 3);
      for (int i = 0; i < 100 && (flen - 3 - fpos) != D + 1; i++) step();
      bus.btn_next = 1'b1;
      steps(D + 2);
      check("coincide_pending", 32'(bus.pending), 32'd1);
      bus.btn_next = 1'b0;
      to_frame_start(); steps(1); to_frame_start();

      // Reset mid-frame drops a pending request.
      press(1'b1, D + 3);
      reset = 1'b1; step(); reset = 1'b0;
      check("rst_drop", 32'(bus.pending), 32'd0);
      to_frame_start();

      // Random traffic.
      rand_frames = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) bus.btn_next = ~bus.btn_next;
         if ($urandom_range(0, 13) == 0) bus.btn_prev = ~bus.btn_prev;
         if ($urandom_range(0, 199) == 0) bus.auto_en = ~bus.auto_en;
         reset = ($urandom_range(0, 1499) == 0);
         step();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
